// File: rtl/microwave_timer_ctrl_if.sv
// Key-entry, control and display bundle between the keypad/prescaler side and the timer controller.
// TIMER_DOOR_EN adds the door_open switch input.
interface microwave_timer_ctrl_if;
    logic [3:0] digit;
    logic       loadn;
    logic       start;
    logic       stop;
    logic       clear;
    logic       tick;
`ifdef TIMER_DOOR_EN
    logic       door_open;
`endif
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       zero;
    logic       done;

`ifdef TIMER_DOOR_EN
    modport master (
        output digit, loadn, start, stop, clear, tick, door_open,
        input  min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );
    modport slave (
        input  digit, loadn, start, stop, clear, tick, door_open,
        output min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );
`else
    modport master (
        output digit, loadn, start, stop, clear, tick,
        input  min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );
    modport slave (
        input  digit, loadn, start, stop, clear, tick,
        output min_tens, min_ones, sec_tens, sec_ones, running, zero, done
    );
`endif
endinterface

// File: rtl/microwave_timer_ctrl.sv
// BCD MM:SS digit-entry and countdown controller for the microwave timer.
// Define TIMER_DOOR_EN to enable the door_open interlock.
module microwave_timer_ctrl (
    input  logic                   clk,
    input  logic                   rstn,
    microwave_timer_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       loadn_q;
    logic       running_q;
    logic       done_q, done_d;

    logic       zero_w;
    logic       press;
    logic       door;
    logic       start_ok;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       dec_zero;

`ifdef TIMER_DOOR_EN
    assign door = bus.door_open;
`else
    assign door = 1'b0;
`endif

    assign zero_w   = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                      (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    assign press    = ~bus.loadn & loadn_q;
    assign start_ok = bus.start & ~door;

    // One-second decrement; seconds tens may legitimately hold 6..9 after entry.
    always_comb begin
        dec_mt = min_tens_q;
        dec_mo = min_ones_q;
        dec_st = sec_tens_q;
        dec_so = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_so = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_st = sec_tens_q - 4'd1;
            dec_so = 4'd9;
        end else if ((min_ones_q != 4'd0) || (min_tens_q != 4'd0)) begin
            dec_st = 4'd5;
            dec_so = 4'd9;
            if (min_ones_q != 4'd0) begin
                dec_mo = min_ones_q - 4'd1;
            end else begin
                dec_mo = 4'd9;
                dec_mt = min_tens_q - 4'd1;
            end
        end
        dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                   (dec_st == 4'd0) && (dec_so == 4'd0);
    end

    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        done_d     = 1'b0;
        if (bus.clear) begin
            state_d    = ST_ENTRY;
            min_tens_d = 4'd0;
            min_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            sec_ones_d = 4'd0;
        end else if (door && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (start_ok && !zero_w) begin
                        state_d = ST_RUN;
                    end else if (press && (bus.digit <= 4'd9)) begin
                        min_tens_d = min_ones_q;
                        min_ones_d = sec_tens_q;
                        sec_tens_d = sec_ones_q;
                        sec_ones_d = bus.digit;
                    end
                end
                ST_RUN: begin
                    // stop wins over a coincident tick, so the tick is lost.
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick) begin
                        min_tens_d = dec_mt;
                        min_ones_d = dec_mo;
                        sec_tens_d = dec_st;
                        sec_ones_d = dec_so;
                        if (dec_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_ok) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ENTRY;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            loadn_q    <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            loadn_q    <= bus.loadn;
            running_q  <= (state_d == ST_RUN);
            done_q     <= done_d;
        end
    end

    assign bus.min_tens = min_tens_q;
    assign bus.min_ones = min_ones_q;
    assign bus.sec_tens = sec_tens_q;
    assign bus.sec_ones = sec_ones_q;
    assign bus.running  = running_q;
    assign bus.zero     = zero_w;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed, table-driven bench for microwave_timer_ctrl; door interlock sequence runs only with TIMER_DOOR_EN.
module tb_microwave_timer_ctrl;
    logic clk;
    logic rstn;
    microwave_timer_ctrl_if bus();

    microwave_timer_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {OP_RST, OP_KEY, OP_START, OP_STOP, OP_CLEAR, OP_TICK,
                      OP_STOP_TICK, OP_START_TICK, OP_IDLE} op_e;

    typedef struct {
        op_e         op;
        logic [3:0]  arg;     // key code
        int          n;       // repeat count for OP_TICK
        logic [15:0] digits;  // expected MM:SS as 4 BCD nibbles
        logic        run;
        logic        zero;
        logic        done;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(op_e op, logic [3:0] arg, int n, logic [15:0] digits,
                                logic run, logic zero, logic done);
        vec_t v;
        v.op = op; v.arg = arg; v.n = n; v.digits = digits;
        v.run = run; v.zero = zero; v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [18:0] exp);
        logic [18:0] act;
        act = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
               bus.running, bus.zero, bus.done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h:%h run=%b zero=%b done=%b, want %h:%h:%h:%h run=%b zero=%b done=%b",
                     name, act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0],
                     exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: %h%h:%h%h run=%b zero=%b done=%b", name,
                     act[18:15], act[14:11], act[10:7], act[6:3], act[2], act[1], act[0]);
        end
    endtask

    task automatic apply(vec_t v);
        case (v.op)
            OP_RST: begin
                rstn = 1'b0; cycle(); cycle(); rstn = 1'b1; cycle();
            end
            OP_KEY: begin
                bus.digit = v.arg; bus.loadn = 1'b0;
                repeat (5) cycle();
                bus.loadn = 1'b1; cycle();
            end
            OP_START:      begin bus.start = 1'b1; cycle(); bus.start = 1'b0; end
            OP_STOP:       begin bus.stop  = 1'b1; cycle(); bus.stop  = 1'b0; end
            OP_CLEAR:      begin bus.clear = 1'b1; cycle(); bus.clear = 1'b0; end
            OP_TICK: begin
                repeat (v.n) begin bus.tick = 1'b1; cycle(); bus.tick = 1'b0; end
            end
            OP_STOP_TICK:  begin bus.stop = 1'b1; bus.tick = 1'b1; cycle(); bus.stop = 1'b0; bus.tick = 1'b0; end
            OP_START_TICK: begin bus.start = 1'b1; bus.tick = 1'b1; cycle(); bus.start = 1'b0; bus.tick = 1'b0; end
            default:       cycle();
        endcase
    endtask

    initial begin
        rstn = 1'b0;
        bus.digit = 4'd0; bus.loadn = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.tick = 1'b0;
`ifdef TIMER_DOOR_EN
        bus.door_open = 1'b0;
`endif
        //   op             key   n   MMSS      run zero done
        add(OP_RST,        4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd1,  0, 16'h0001, 0, 0, 0);
        add(OP_KEY,        4'd2,  0, 16'h0012, 0, 0, 0);
        add(OP_KEY,        4'd3,  0, 16'h0123, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h1230, 0, 0, 0);
        add(OP_KEY,        4'd12, 0, 16'h1230, 0, 0, 0);
        add(OP_KEY,        4'd5,  0, 16'h2305, 0, 0, 0);
        add(OP_CLEAR,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_START,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd1,  0, 16'h0001, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0010, 0, 0, 0);
        add(OP_START,      4'd0,  0, 16'h0010, 1, 0, 0);
        add(OP_KEY,        4'd7,  0, 16'h0010, 1, 0, 0);
        add(OP_STOP_TICK,  4'd0,  0, 16'h0010, 0, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0010, 0, 0, 0);
        add(OP_START_TICK, 4'd0,  0, 16'h0010, 1, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0009, 1, 0, 0);
        add(OP_STOP,       4'd0,  0, 16'h0009, 0, 0, 0);
        add(OP_KEY,        4'd4,  0, 16'h0009, 0, 0, 0);
        add(OP_CLEAR,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd1,  0, 16'h0001, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0010, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0100, 0, 0, 0);
        add(OP_START,      4'd0,  0, 16'h0100, 1, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0059, 1, 0, 0);
        add(OP_TICK,       4'd0, 58, 16'h0001, 1, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0000, 0, 1, 1);
        add(OP_IDLE,       4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_START,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd4,  0, 16'h0000, 0, 1, 0);
        add(OP_CLEAR,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd4,  0, 16'h0004, 0, 0, 0);
        add(OP_KEY,        4'd9,  0, 16'h0049, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0490, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h4900, 0, 0, 0);
        add(OP_CLEAR,      4'd0,  0, 16'h0000, 0, 1, 0);
        add(OP_KEY,        4'd1,  0, 16'h0001, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0010, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h0100, 0, 0, 0);
        add(OP_KEY,        4'd0,  0, 16'h1000, 0, 0, 0);
        add(OP_START,      4'd0,  0, 16'h1000, 1, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0959, 1, 0, 0);
        add(OP_KEY,        4'd9,  0, 16'h0959, 1, 0, 0);
        add(OP_TICK,       4'd0,  1, 16'h0958, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_%s", i, vecs[i].op.name()),
                  {vecs[i].digits, vecs[i].run, vecs[i].zero, vecs[i].done});
        end

        // Asynchronous reset while running: must clear without any clock edge.
        @(negedge clk);
        rstn = 1'b0;
        #2;
        check("async_rst_midrun", {16'h0000, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        check("after_rst_release", {16'h0000, 1'b0, 1'b1, 1'b0});

        // A key held from one press to the next edge must not load twice.
        bus.digit = 4'd6; bus.loadn = 1'b0;
        cycle();
        check("key_first_edge", {16'h0006, 1'b0, 1'b0, 1'b0});
        repeat (3) cycle();
        check("key_held", {16'h0006, 1'b0, 1'b0, 1'b0});
        bus.loadn = 1'b1; cycle();

`ifdef TIMER_DOOR_EN
        bus.clear = 1'b1; cycle(); bus.clear = 1'b0;
        bus.digit = 4'd3; bus.loadn = 1'b0; cycle(); bus.loadn = 1'b1; cycle();
        bus.digit = 4'd0; bus.loadn = 1'b0; cycle(); bus.loadn = 1'b1; cycle();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        check("door_run_0030", {16'h0030, 1'b1, 1'b0, 1'b0});
        bus.door_open = 1'b1; bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
        check("door_open_pause", {16'h0030, 1'b0, 1'b0, 1'b0});
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        check("door_start_ignored", {16'h0030, 1'b0, 1'b0, 1'b0});
        bus.door_open = 1'b0; cycle();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        check("door_closed_start", {16'h0030, 1'b1, 1'b0, 1'b0});
        bus.tick = 1'b1; cycle(); bus.tick = 1'b0;
        check("door_closed_tick", {16'h0029, 1'b1, 1'b0, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
